// File: rtl/data_sram_bridge_if.sv
// Variable-latency bus between the data SRAM bridge (master) and memory (slave).
// One request is outstanding at a time; req is held until addr_ok.
interface data_sram_bridge_if;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Converts the core's fixed-latency data_sram port into a req/addr_ok/data_ok bus.
// Stores are posted through a small write buffer; loads stall until the buffer drains and data returns.
module data_sram_bridge #(
    parameter int unsigned WBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_sram_en,
    input  logic [3:0]            data_sram_wen,
    input  logic [31:0]           data_sram_addr,
    input  logic [31:0]           data_sram_wdata,
    output logic [31:0]           data_sram_rdata,
    output logic                  mem_stall,
    data_sram_bridge_if.master    bus
);

    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wbuf_entry_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_REQ  = 3'd1,
        W_WAIT = 3'd2,
        R_REQ  = 3'd3,
        R_WAIT = 3'd4,
        R_DONE = 3'd5
    } state_t;

    state_t             state_q;
    wbuf_entry_t        wbuf_q [WBUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        rdata_q;

    logic               is_store_c;
    logic               is_load_c;
    logic               fifo_full_c;
    logic               fifo_empty_c;
    logic               push_c;
    logic               pop_c;
    wbuf_entry_t        head_c;

    assign is_store_c   = data_sram_en & (|data_sram_wen);
    assign is_load_c    = data_sram_en & ~(|data_sram_wen);
    assign fifo_full_c  = (count_q == CNT_W'(WBUF_DEPTH));
    assign fifo_empty_c = (count_q == '0);
    assign push_c       = is_store_c & ~fifo_full_c;
    assign pop_c        = (state_q == W_REQ) & bus.bus_addr_ok;
    assign head_c       = wbuf_q[rd_ptr_q];

    // Loads hold the core until their single completion cycle; stores only when the buffer is full.
    assign mem_stall       = (is_load_c & (state_q != R_DONE)) | (is_store_c & fifo_full_c);
    assign data_sram_rdata = rdata_q;

    // Buffer storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            wbuf_q[wr_ptr_q] <= '{addr: data_sram_addr, wdata: data_sram_wdata, wstrb: data_sram_wen};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Bus FSM with registered bus outputs; writes may launch straight out of R_DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_wstrb <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rdata_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_load_c && fifo_empty_c) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= 1'b0;
                        bus.bus_wstrb <= '0;
                        bus.bus_addr  <= data_sram_addr;
                        state_q       <= R_REQ;
                    end else if (!fifo_empty_c) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= 1'b1;
                        bus.bus_wstrb <= head_c.wstrb;
                        bus.bus_addr  <= head_c.addr;
                        bus.bus_wdata <= head_c.wdata;
                        state_q       <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (bus.bus_addr_ok) begin
                        bus.bus_req <= 1'b0;
                        state_q     <= bus.bus_data_ok ? IDLE : W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (bus.bus_data_ok) state_q <= IDLE;
                end
                R_REQ: begin
                    if (bus.bus_addr_ok) begin
                        bus.bus_req <= 1'b0;
                        if (bus.bus_data_ok) begin
                            rdata_q <= bus.bus_rdata;
                            state_q <= R_DONE;
                        end else begin
                            state_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (bus.bus_data_ok) begin
                        rdata_q <= bus.bus_rdata;
                        state_q <= R_DONE;
                    end
                end
                R_DONE: begin
                    if (!fifo_empty_c) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= 1'b1;
                        bus.bus_wstrb <= head_c.wstrb;
                        bus.bus_addr  <= head_c.addr;
                        bus.bus_wdata <= head_c.wdata;
                        state_q       <= W_REQ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: a cycle table for store/drain/load flows
// plus hand sequences for delayed-data ordering and reset during a read.
module tb_data_sram_bridge;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;

    int total;
    int bad;

    data_sram_bridge_if bus_if ();

    data_sram_bridge #(.WBUF_DEPTH(2)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .mem_stall       (stall),
        .bus             (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] brdata;
        logic        x_stall;
        logic        x_req;
        logic        x_wr;
        logic [3:0]  x_wstrb;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] wd, input logic aok, input logic dok,
                                input logic [31:0] brd, input logic xs, input logic xr,
                                input logic xw, input logic [3:0] xst, input logic [31:0] xa,
                                input logic [31:0] xwd, input logic [31:0] xrd);
        vec_t v;
        v.en = e; v.wen = w; v.addr = a; v.wdata = wd;
        v.aok = aok; v.dok = dok; v.brdata = brd;
        v.x_stall = xs; v.x_req = xr; v.x_wr = xw; v.x_wstrb = xst;
        v.x_addr = xa; v.x_wdata = xwd; v.x_rdata = xrd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle before checking.
    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input logic aok, input logic dok,
                       input logic [31:0] brd);
        @(negedge clk);
        en = e; wen = w; addr = a; wdata = wd;
        bus_if.bus_addr_ok = aok;
        bus_if.bus_data_ok = dok;
        bus_if.bus_rdata   = brd;
        #1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_req"},   32'(bus_if.bus_req),   32'h0);
        chk({tag, "_wr"},    32'(bus_if.bus_wr),    32'h0);
        chk({tag, "_wstrb"}, 32'(bus_if.bus_wstrb), 32'h0);
        chk({tag, "_addr"},  bus_if.bus_addr,       32'h0);
        chk({tag, "_wdata"}, bus_if.bus_wdata,      32'h0);
        chk({tag, "_rdata"}, rdata,                 32'h0);
        chk({tag, "_stall"}, 32'(stall),            32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        en = 1'b0; wen = '0; addr = '0; wdata = '0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_rdata   = '0;

        // T1: single posted store, bus always ready
        vq.push_back(mk(1, 4'hF, 32'h100, 32'h11223344, 1, 1, 0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,   32'h0,        1, 1, 0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,   32'h0,        1, 1, 0,  0, 1, 1, 4'hF, 32'h100, 32'h11223344, 32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,   32'h0,        1, 1, 0,  0, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0));
        // T2: three stores against a stalled bus
        vq.push_back(mk(1, 4'hF, 32'h10, 32'hA0000001, 0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(1, 4'hF, 32'h14, 32'hA0000002, 0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(1, 4'hF, 32'h18, 32'hA0000003, 0, 0, 0,  1, 1, 1, 4'hF, 32'h10, 32'hA0000001, 32'h0));
        vq.push_back(mk(1, 4'hF, 32'h18, 32'hA0000003, 0, 0, 0,  1, 1, 1, 4'hF, 32'h10, 32'hA0000001, 32'h0));
        vq.push_back(mk(1, 4'hF, 32'h18, 32'hA0000003, 1, 0, 0,  1, 1, 1, 4'hF, 32'h10, 32'hA0000001, 32'h0));
        vq.push_back(mk(1, 4'hF, 32'h18, 32'hA0000003, 0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 1, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        1, 1, 0,  0, 1, 1, 4'hF, 32'h14, 32'hA0000002, 32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        1, 1, 0,  0, 1, 1, 4'hF, 32'h18, 32'hA0000003, 32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        // T6: byte store pushed in the same cycle the head is popped
        vq.push_back(mk(1, 4'hF, 32'h20, 32'hB0000000, 0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(1, 4'h2, 32'h22, 32'h0000CC00, 1, 1, 0,  0, 1, 1, 4'hF, 32'h20, 32'hB0000000, 32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        1, 1, 0,  0, 1, 1, 4'h2, 32'h22, 32'h0000CC00, 32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        vq.push_back(mk(0, 4'h0, 32'h0,  32'h0,        0, 0, 0,  0, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0));
        // T4: load with addr_ok and data_ok together
        vq.push_back(mk(1, 4'h0, 32'h300, 32'h0, 1, 1, 32'hDEADBEEF,  1, 0, 0, 4'h0, 32'h0,   32'h0, 32'h0));
        vq.push_back(mk(1, 4'h0, 32'h300, 32'h0, 1, 1, 32'hDEADBEEF,  1, 1, 0, 4'h0, 32'h300, 32'h0, 32'h0));
        vq.push_back(mk(1, 4'h0, 32'h300, 32'h0, 0, 0, 32'h0,         0, 0, 0, 4'h0, 32'h0,   32'h0, 32'hDEADBEEF));
        vq.push_back(mk(0, 4'h0, 32'h0,   32'h0, 0, 0, 32'h0,         0, 0, 0, 4'h0, 32'h0,   32'h0, 32'hDEADBEEF));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_outs_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].en, vq[i].wen, vq[i].addr, vq[i].wdata, vq[i].aok, vq[i].dok, vq[i].brdata);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vq[i].x_stall));
            chk($sformatf("v%0d_req", i),   32'(bus_if.bus_req), 32'(vq[i].x_req));
            chk($sformatf("v%0d_rdata", i), rdata, vq[i].x_rdata);
            if (vq[i].x_req) begin
                chk($sformatf("v%0d_wr", i),   32'(bus_if.bus_wr), 32'(vq[i].x_wr));
                chk($sformatf("v%0d_addr", i), bus_if.bus_addr, vq[i].x_addr);
                if (vq[i].x_wr) begin
                    chk($sformatf("v%0d_wstrb", i), 32'(bus_if.bus_wstrb), 32'(vq[i].x_wstrb));
                    chk($sformatf("v%0d_wdata", i), bus_if.bus_wdata, vq[i].x_wdata);
                end
            end
        end

        // T3: store then load to the same address, data_ok delayed 5 cycles each
        cyc(1, 4'hF, 32'h200, 32'hA5A5A5A5, 0, 0, 0);
        chk("t3_store_stall", 32'(stall), 32'h0);
        cyc(1, 4'h0, 32'h200, 32'h0, 0, 0, 0);
        chk("t3_load_stall0", 32'(stall), 32'h1);
        chk("t3_req_idle", 32'(bus_if.bus_req), 32'h0);
        cyc(1, 4'h0, 32'h200, 32'h0, 1, 0, 0);
        chk("t3_wreq", 32'(bus_if.bus_req), 32'h1);
        chk("t3_wr_first", 32'(bus_if.bus_wr), 32'h1);
        chk("t3_waddr", bus_if.bus_addr, 32'h200);
        chk("t3_wdata", bus_if.bus_wdata, 32'hA5A5A5A5);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 4'h0, 32'h200, 32'h0, 0, 0, 0);
            chk($sformatf("t3_wwait%0d_stall", k), 32'(stall), 32'h1);
            chk($sformatf("t3_wwait%0d_req", k), 32'(bus_if.bus_req), 32'h0);
        end
        cyc(1, 4'h0, 32'h200, 32'h0, 0, 1, 0);
        chk("t3_wdone_stall", 32'(stall), 32'h1);
        cyc(1, 4'h0, 32'h200, 32'h0, 0, 0, 0);
        chk("t3_idle_stall", 32'(stall), 32'h1);
        chk("t3_idle_req", 32'(bus_if.bus_req), 32'h0);
        cyc(1, 4'h0, 32'h200, 32'h0, 1, 0, 0);
        chk("t3_rreq", 32'(bus_if.bus_req), 32'h1);
        chk("t3_wr_second", 32'(bus_if.bus_wr), 32'h0);
        chk("t3_raddr", bus_if.bus_addr, 32'h200);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 4'h0, 32'h200, 32'h0, 0, 0, 0);
            chk($sformatf("t3_rwait%0d_stall", k), 32'(stall), 32'h1);
            chk($sformatf("t3_rwait%0d_rdata", k), rdata, 32'hDEADBEEF);
        end
        cyc(1, 4'h0, 32'h200, 32'h0, 0, 1, 32'hCAFEF00D);
        chk("t3_dok_stall", 32'(stall), 32'h1);
        cyc(1, 4'h0, 32'h200, 32'h0, 0, 0, 0);
        chk("t3_rdone_stall", 32'(stall), 32'h0);
        chk("t3_rdone_rdata", rdata, 32'hCAFEF00D);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        chk("t3_after_stall", 32'(stall), 32'h0);
        chk("t3_after_rdata", rdata, 32'hCAFEF00D);
        chk("t3_after_req", 32'(bus_if.bus_req), 32'h0);

        // T5: asynchronous reset while waiting for read data
        cyc(1, 4'h0, 32'h400, 32'h0, 0, 0, 0);
        cyc(1, 4'h0, 32'h400, 32'h0, 1, 0, 0);
        chk("t5_rreq", 32'(bus_if.bus_req), 32'h1);
        chk("t5_raddr", bus_if.bus_addr, 32'h400);
        cyc(1, 4'h0, 32'h400, 32'h0, 0, 0, 0);
        chk("t5_rwait_stall", 32'(stall), 32'h1);
        #2;
        resetn = 1'b0;
        en = 1'b0;
        #1;
        chk_outs_zero("t5_rst");
        @(negedge clk);
        resetn = 1'b1;
        cyc(1, 4'h0, 32'h500, 32'h0, 1, 1, 32'h12345678);
        chk("t5_post_stall", 32'(stall), 32'h1);
        chk("t5_post_req0", 32'(bus_if.bus_req), 32'h0);
        cyc(1, 4'h0, 32'h500, 32'h0, 1, 1, 32'h12345678);
        chk("t5_post_req1", 32'(bus_if.bus_req), 32'h1);
        chk("t5_post_wr", 32'(bus_if.bus_wr), 32'h0);
        chk("t5_post_addr", bus_if.bus_addr, 32'h500);
        cyc(1, 4'h0, 32'h500, 32'h0, 0, 0, 0);
        chk("t5_post_done_stall", 32'(stall), 32'h0);
        chk("t5_post_rdata", rdata, 32'h12345678);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
